// File: rtl/spi_master_nch_if.sv
// spi_master_nch_if: control-side bundle between the SPI register block
// and the SPI master engine (request, mode bits, result, status).
interface spi_master_nch_if #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 4
);
   localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic [CS_W-1:0]   cs_sel;
   logic              cpol;
   logic              cpha;
   logic              lsb_first;
   logic              hold_cs;
   logic [DATA_W-1:0] rx_data;
   logic              done;
   logic              ready;

   modport master (
      output start, tx_data, cs_sel, cpol, cpha, lsb_first, hold_cs,
      input  rx_data, done, ready
   );

   modport slave (
      input  start, tx_data, cs_sel, cpol, cpha, lsb_first, hold_cs,
      output rx_data, done, ready
   );
endinterface

// File: rtl/spi_master_nch.sv
// spi_master_nch: full-duplex SPI master, four CPOL/CPHA modes, MSB/LSB
// first, fixed SCLK divider, one-hot active-low chip selects with CS hold.
module spi_master_nch #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4,
   parameter int NUM_CS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   spi_master_nch_if.slave   bus,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO,
   output logic [NUM_CS-1:0] CS_n
);
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int E_W   = $clog2(2 * DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
   localparam logic [E_W-1:0]   E_LAST  = E_W'(2 * DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      XFER,
      CS_HOLD,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [E_W-1:0]    ecnt;
   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-1:0] rx_sh;
   logic [DATA_W-1:0] rx_in;
   logic [NUM_CS-1:0] cs_dec;
   logic              cpha_q;
   logic              lsb_q;
   logic              hold_q;
   logic              tick;
   logic              last;
   logic              lead;

   function automatic logic pick(input logic [DATA_W-1:0] w,
                                 input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] w,
                                             input logic lsb);
      return lsb ? (w >> 1) : (w << 1);
   endfunction

   assign tick  = (cnt == CNT_MAX);
   assign last  = (ecnt == E_LAST);
   // ecnt counts completed edges, so an even count means the next is odd
   assign lead  = ~ecnt[0];
   assign rx_in = lsb_q ? {MISO, rx_sh[DATA_W-1:1]}
                        : {rx_sh[DATA_W-2:0], MISO};

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state and status outputs
   always_comb begin
      state_nx  = state;
      bus.ready = 1'b0;
      bus.done  = 1'b0;
      unique case (state)
         IDLE: begin
            bus.ready = 1'b1;
            if (bus.start) state_nx = CS_SETUP;
         end
         CS_SETUP: if (tick) state_nx = XFER;
         XFER:     if (tick && last) state_nx = CS_HOLD;
         CS_HOLD:  if (tick) state_nx = DONE;
         DONE: begin
            bus.done = 1'b1;
            state_nx = IDLE;
         end
         default:  state_nx = IDLE;
      endcase
   end

   // One-hot active-low select; out-of-range index selects nothing
   always_comb begin
      cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (int'(bus.cs_sel) == i) cs_dec[i] = 1'b0;
      end
   end

   // Half-period divider and SCLK edge counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         ecnt <= '0;
      end else begin
         if (state == IDLE || state_nx != state || tick) cnt <= '0;
         else cnt <= cnt + 1'b1;
         if (state == IDLE) ecnt <= '0;
         else if (state == XFER && tick) ecnt <= ecnt + 1'b1;
      end
   end

   // Request latch, shift registers and serial pins
   always_ff @(posedge clk) begin
      if (rst) begin
         SCLK        <= 1'b0;
         MOSI        <= 1'b0;
         CS_n        <= '1;
         bus.rx_data <= '0;
         tx_sh       <= '0;
         rx_sh       <= '0;
         cpha_q      <= 1'b0;
         lsb_q       <= 1'b0;
         hold_q      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               SCLK <= bus.cpol;
               if (bus.start) begin
                  cpha_q <= bus.cpha;
                  lsb_q  <= bus.lsb_first;
                  hold_q <= bus.hold_cs;
                  CS_n   <= cs_dec;
                  if (!bus.cpha) begin
                     MOSI  <= pick(bus.tx_data, bus.lsb_first);
                     tx_sh <= adv(bus.tx_data, bus.lsb_first);
                  end else begin
                     tx_sh <= bus.tx_data;
                  end
               end
            end
            XFER: begin
               if (tick) begin
                  SCLK <= ~SCLK;
                  if (lead == !cpha_q) begin
                     rx_sh <= rx_in;
                  end else if (cpha_q || !last) begin
                     MOSI  <= pick(tx_sh, lsb_q);
                     tx_sh <= adv(tx_sh, lsb_q);
                  end
               end
            end
            CS_HOLD: begin
               if (tick) begin
                  bus.rx_data <= rx_sh;
                  if (!hold_q) CS_n <= '1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_nch.sv
// tb_spi_master_nch: vector table over modes/bit order/CS lines, plus
// hand sequences for CS hold, ignored start and mid-transfer reset.
module tb_spi_master_nch;
   typedef struct {
      logic       cpol;
      logic       cpha;
      logic       lsb;
      logic       hold;
      logic [1:0] cs;
      logic [7:0] tx;
      logic       loop;
      logic [7:0] sword;
      logic [7:0] exp_rx;
      logic [3:0] exp_csd;
      logic [7:0] exp_srx;
   } vec_t;

   typedef struct {
      logic       sclk_pre;
      int         lat;
      int         edges;
      logic [3:0] csd;
      logic [7:0] rx;
      logic [7:0] srx;
      logic       sclk_done;
      logic [3:0] cs_after;
      logic       ready_after;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       SCLK;
   logic       MOSI;
   logic       MISO;
   logic [3:0] CS_n;
   logic       loop = 1'b1;
   logic       slave_miso = 1'b0;
   logic [7:0] s_word = '0;
   logic [7:0] s_sh = '0;
   logic [7:0] s_rx = '0;
   logic       s_cpol = 1'b0;
   logic       s_cpha = 1'b0;
   int         s_cs = 0;
   logic       sclk_prev = 1'b0;
   logic       cs_prev = 1'b1;
   logic       mon_cs2 = 1'b0;
   int         n_cmp = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   int         cs2_hi = 0;
   vec_t       vt[6];

   spi_master_nch_if #(.DATA_W(8), .NUM_CS(4)) bus ();

   spi_master_nch #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .SCLK (SCLK),
      .MOSI (MOSI),
      .MISO (MISO),
      .CS_n (CS_n)
   );

   always #5 clk = ~clk;

   assign MISO = loop ? MOSI : slave_miso;

   // MSB-first SPI slave, evaluated mid-cycle on the falling clk edge
   always @(negedge clk) begin
      if (cs_prev === 1'b1 && CS_n[s_cs] === 1'b0) begin
         s_sh = s_word;
         s_rx = '0;
         if (!s_cpha) begin
            slave_miso = s_sh[7];
            s_sh = s_sh << 1;
         end
      end else if (CS_n[s_cs] === 1'b0 && SCLK !== sclk_prev) begin
         if ((sclk_prev == s_cpol) == s_cpha) begin
            slave_miso = s_sh[7];
            s_sh = s_sh << 1;
         end else begin
            s_rx = {s_rx[6:0], MOSI};
         end
      end
      sclk_prev = SCLK;
      cs_prev   = CS_n[s_cs];
   end

   // Done pulses and CS_n[2] gaps seen by the bus side
   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
      if (mon_cs2 && CS_n[2] !== 1'b0) cs2_hi++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      bus.cpol      = v.cpol;
      bus.cpha      = v.cpha;
      bus.lsb_first = v.lsb;
      bus.hold_cs   = v.hold;
      bus.cs_sel    = v.cs;
      bus.tx_data   = v.tx;
      loop          = v.loop;
      s_word        = v.sword;
      s_cpol        = v.cpol;
      s_cpha        = v.cpha;
      s_cs          = int'(v.cs);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (bus.done !== 1'b1 && cyc < budget);
      if (bus.done !== 1'b1) cyc = -1;
   endtask

   task automatic run(input vec_t v, output res_t r);
      logic prev;
      int   cyc;
      apply(v);
      repeat (2) @(posedge clk);
      #1;
      r.sclk_pre = SCLK;
      pulse_start();
      bus.tx_data   = ~v.tx;
      bus.cpol      = ~v.cpol;
      bus.cpha      = ~v.cpha;
      bus.lsb_first = ~v.lsb;
      bus.hold_cs   = ~v.hold;
      bus.cs_sel    = v.cs + 2'd1;
      prev    = SCLK;
      r.edges = 0;
      r.lat   = 0;
      r.csd   = '0;
      cyc     = 1;
      while (cyc < 200) begin
         if (SCLK !== prev) r.edges++;
         prev = SCLK;
         if (cyc == 40) r.csd = CS_n;
         if (bus.done === 1'b1) begin
            r.lat = cyc;
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      r.rx        = bus.rx_data;
      r.srx       = s_rx;
      r.sclk_done = SCLK;
      apply(v);
      @(posedge clk);
      #1;
      r.cs_after    = CS_n;
      r.ready_after = bus.ready;
   endtask

   initial begin
      res_t r;
      vec_t vr;
      int   cyc;
      int   d0;

      vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'hAA, 1'b1, 8'h00,
                8'hAA, 4'b1110, 8'hAA};
      vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'hBB, 1'b1, 8'h00,
                8'hBB, 4'b1110, 8'hBB};
      vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'h3C, 1'b0, 8'h5A,
                8'h5A, 4'b1101, 8'h3C};
      vt[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h3C, 1'b0, 8'h5A,
                8'h5A, 4'b0111, 8'h3C};
      vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h01, 1'b1, 8'h00,
                8'h01, 4'b1110, 8'h80};
      vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 8'h12, 1'b0, 8'h35,
                8'hAC, 4'b1011, 8'h48};

      rst       = 1'b1;
      bus.start = 1'b0;
      apply(vt[0]);
      repeat (3) @(posedge clk);
      #1;
      chk("reset SCLK", SCLK, 0);
      chk("reset MOSI", MOSI, 0);
      chk("reset CS_n", CS_n, 4'hF);
      chk("reset rx_data", bus.rx_data, 0);
      chk("reset done", bus.done, 0);
      chk("reset ready", bus.ready, 1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run(vt[i], r);
         chk($sformatf("v%0d sclk idle before", i), r.sclk_pre, vt[i].cpol);
         chk($sformatf("v%0d done cycle", i), r.lat, 73);
         chk($sformatf("v%0d sclk edges", i), r.edges, 16);
         chk($sformatf("v%0d cs_n during", i), r.csd, vt[i].exp_csd);
         chk($sformatf("v%0d rx_data", i), r.rx, vt[i].exp_rx);
         chk($sformatf("v%0d slave rx", i), r.srx, vt[i].exp_srx);
         chk($sformatf("v%0d sclk idle after", i), r.sclk_done, vt[i].cpol);
         chk($sformatf("v%0d cs_n after", i), r.cs_after, 4'hF);
         chk($sformatf("v%0d ready after", i), r.ready_after, 1);
      end

      vr = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h11, 1'b1, 8'h00,
             8'h11, 4'b1011, 8'h00};
      d0 = done_cnt;
      apply(vr);
      repeat (2) @(posedge clk);
      pulse_start();
      mon_cs2 = 1'b1;
      repeat (30) @(posedge clk);
      bus.tx_data = 8'h77;
      pulse_start();
      bus.tx_data = 8'h11;
      wait_done(200, cyc);
      chk("hold1 done seen", cyc > 0, 1);
      chk("hold1 rx_data", bus.rx_data, 8'h11);
      @(posedge clk);
      #1;
      chk("hold1 cs_n held in idle", CS_n, 4'b1011);
      repeat (5) @(posedge clk);
      #1;
      chk("ignored start stays idle", bus.ready, 1);
      chk("hold1 one done", done_cnt - d0, 1);
      vr.hold = 1'b0;
      vr.tx   = 8'h22;
      apply(vr);
      pulse_start();
      wait_done(200, cyc);
      mon_cs2 = 1'b0;
      chk("hold2 done cycle", cyc, 72);
      chk("hold2 rx_data", bus.rx_data, 8'h22);
      chk("cs2 continuous low", cs2_hi, 0);
      @(posedge clk);
      #1;
      chk("hold2 cs_n released", CS_n, 4'hF);
      chk("hold total dones", done_cnt - d0, 2);

      vr = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h96, 1'b1, 8'h00,
             8'h96, 4'b1101, 8'h96};
      d0 = done_cnt;
      apply(vr);
      repeat (2) @(posedge clk);
      pulse_start();
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort CS_n", CS_n, 4'hF);
      chk("abort SCLK", SCLK, 0);
      chk("abort ready", bus.ready, 1);
      chk("abort done", bus.done, 0);
      repeat (80) @(posedge clk);
      #1;
      chk("abort no done", done_cnt - d0, 0);
      run(vr, r);
      chk("post-abort done cycle", r.lat, 73);
      chk("post-abort rx_data", r.rx, 8'h96);
      chk("post-abort edges", r.edges, 16);
      chk("post-abort cs_n during", r.csd, 4'b1101);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
